// File: rtl/vga_sync_if.sv
// Timing bundle from the VGA sync generator to the object renderers and RGB mux.
interface vga_sync_if;
  logic [9:0] HCount;
  logic [9:0] VCount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic       frame_end;

  modport master (
    output HCount, VCount, hsync, vsync, video_on, p_tick, frame_end
  );

  modport slave (
    input HCount, VCount, hsync, vsync, video_on, p_tick, frame_end
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, horizontal/vertical counters,
// active-low sync pulses and the visible-area qualifier.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_q, div_next;
  logic [9:0] hcount_q, vcount_q;
  logic [9:0] h_next, v_next;
  logic       p_tick_q;
  logic       hsync_q, vsync_q, video_on_q;

  // Next-state divider and counters; counters move only on a pixel strobe.
  always_comb begin
    div_next = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    h_next   = hcount_q;
    v_next   = vcount_q;
    if (p_tick_q) begin
      if (hcount_q == H_LAST) begin
        h_next = 10'd0;
        v_next = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
      end else begin
        h_next = hcount_q + 10'd1;
      end
    end
  end

  // State update; sync/blank flags are decoded from the next counter values
  // so they line up with HCount/VCount without an extra cycle of lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= 4'd0;
      p_tick_q   <= 1'b0;
      hcount_q   <= 10'd0;
      vcount_q   <= 10'd0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b1;
    end else begin
      div_q      <= div_next;
      p_tick_q   <= (div_next == DIV_LAST);
      hcount_q   <= h_next;
      vcount_q   <= v_next;
      hsync_q    <= ~((h_next >= HS_START) && (h_next <= HS_END));
      vsync_q    <= ~((v_next >= VS_START) && (v_next <= VS_END));
      video_on_q <= (h_next < H_VIS) && (v_next < V_VIS);
    end
  end

  assign vga.HCount    = hcount_q;
  assign vga.VCount    = vcount_q;
  assign vga.hsync     = hsync_q;
  assign vga.vsync     = vsync_q;
  assign vga.video_on  = video_on_q;
  assign vga.p_tick    = p_tick_q;
  assign vga.frame_end = p_tick_q && (hcount_q == H_LAST) && (vcount_q == V_LAST);

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Timing generator for the 640x480@60 Hz VGA display path. Divides the system clock down to the pixel rate and runs the horizontal and vertical pixel counters. Produces HCount/VCount for the object ROM stages, which compare against them, plus the active-low hsync/vsync and a video_on blanking qualifier for the RGB output mux. Sits directly upstream of every object_* renderer.

Parameters:
CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz); legal range 1..16
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch, in pixels
H_SYNC, 96, hsync pulse width, in pixels
H_BACK, 48, horizontal back porch, in pixels
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch, in lines
V_SYNC, 2, vsync pulse width, in lines
V_BACK, 33, vertical back porch, in lines

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
HCount  out  10  current pixel column, 0..H_TOTAL-1
VCount  out  10  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
video_on  out  1  high while HCount<H_DISPLAY and VCount<V_DISPLAY
p_tick  out  1  one-clk strobe, one per pixel period
frame_end  out  1  one-clk strobe on the last pixel of a frame

Behaviour:
- Derived: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = 525. Both must be <= 1024.
- All state is updated on the rising edge of clk. Reset is synchronous and active-high and has priority over every other event.
- Reset values: divider=0, HCount=0, VCount=0, hsync=1, vsync=1, video_on=1, p_tick=0, frame_end=0.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - p_tick is high for exactly the one clk in which the divider equals CLK_DIV-1.
  - With CLK_DIV=1, p_tick is held high continuously after reset.
- Counter advance:
  - The counters advance only on clocks in which p_tick=1.
  - If HCount=H_TOTAL-1, HCount wraps to 0 and VCount advances; otherwise HCount increments by 1.
  - If VCount=V_TOTAL-1 when it advances, VCount wraps to 0; otherwise it increments by 1.
  - Between p_tick strobes, HCount and VCount hold their values.
- hsync, vsync and video_on are registers loaded from the next-state counter values. They therefore always equal a decode of the current HCount/VCount, with no extra cycle of lag.
  - hsync=0 iff H_DISPLAY+H_FRONT <= HCount <= H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
  - vsync=0 iff V_DISPLAY+V_FRONT <= VCount <= V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491.
  - video_on=1 iff HCount<H_DISPLAY and VCount<V_DISPLAY.
- frame_end is a combinational AND of p_tick, HCount==H_TOTAL-1 and VCount==V_TOTAL-1. It is high for exactly one clk per frame, on the clock edge that wraps both counters to 0.
- Arithmetic is unsigned 10-bit. Counter compares are equality against TOTAL-1 only, so there is no overflow path.
- Reset mid-frame: on the first clk with reset=1, all outputs return to their reset values. Counting resumes at (0,0) CLK_DIV clocks after reset is released. No partial sync pulse is stretched.
- Downstream contract: renderers sample HCount/VCount combinationally. The values are stable for CLK_DIV clocks between changes.

Test Plan:
- Hold reset for 3 clks, then release -> HCount=VCount=0, hsync=vsync=1, video_on=1 throughout reset; first p_tick on the 2nd clk after release; HCount=1 on the following edge.
- Run one full line -> 800 p_ticks per line. hsync low for exactly 96 pixel periods, starting at HCount=656 and ending after 751. video_on falls at HCount=640. VCount increments exactly when HCount wraps 799->0.
- Run one full frame -> frame_end pulses once after 420000 p_ticks (1 clk wide, coincident with the wrap to 0,0). vsync low for VCount 490..491 (1600 pixel periods). video_on is never high for VCount>=480.
- Assert reset at HCount=700, VCount=491 (mid-hsync, mid-vsync) -> on the next edge hsync=vsync=1 and counters=0; no residual low pulse appears.
- Instantiate with CLK_DIV=1 -> p_tick is constantly 1 after reset, HCount advances every clk, and the line period is 800 clks.
- Check against the object stage: drive the generated HCount/VCount into a renderer placed at x 5..204, y 165..314 -> its on-flag is asserted only while video_on=1, for 200 pixels per line across 150 lines.
